// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, register offsets and STATUS bit positions for mmio_uart_tx.
// Optional feature macro: UART_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;
    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty detection.
// Ports: CLK, RST (async, active-high); push/din write side; pop/dout read side (dout is
//        the current head, valid while !empty); full/empty status.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic wr;
    always_comb begin
        full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        empty = wp_q == rp_q;
        wr    = push && (!full || pop);
        wp_d  = wr ? wp_q + ONE : wp_q;
        rp_d  = (pop && !empty) ? rp_q + ONE : rp_q;
        dout  = mem[rp_q[AW-1:0]];
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (wr) mem[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter fed by the core store stream.
// Ports: CLK, RST (async, active-high); wen/ren/addr/wdata load-store bus (addr[1:0] ignored);
//        rdata registered load data; tx serial line (idle high); busy while a frame shifts
//        or bytes are queued.
// Registers: BASE+0 TXDATA (write pushes wdata[7:0]); BASE+4 STATUS (bit0 full, bit1 empty,
//        bit2 busy, bit3 sticky overflow cleared by writing bit3=1, bit4 parity enabled).
// Optional feature macro: UART_PARITY_EN inserts an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0F00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE = 1;
    localparam logic [31:0] TX_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0] ST_ADDR = BASE_ADDR + STATUS_OFS;
`ifdef UART_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
    localparam logic PAR_EN = 1'b1;
`else
    localparam uart_state_e AFTER_DATA = STOP;
    localparam logic PAR_EN = 1'b0;
`endif
    uart_state_e state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, fifo_dout;
    logic tx_q, tx_d, ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d, status;
    logic hit_tx, hit_st, push, pop, full, empty, baud_done;
`ifdef UART_PARITY_EN
    logic par_q, par_d;
`endif
    logic unused;
    assign unused = ^{addr[1:0], wdata[31:8]};
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .full  (full),
        .empty (empty),
        .dout  (fifo_dout)
    );
    always_comb begin
        hit_tx    = addr[31:2] == TX_ADDR[31:2];
        hit_st    = addr[31:2] == ST_ADDR[31:2];
        push      = wen && hit_tx;
        baud_done = baud_q == BAUD_LAST;
        // the next byte leaves the FIFO either from idle or straight out of a finished stop bit
        pop       = !empty && (state_q == IDLE || (state_q == STOP && baud_done));
        busy      = state_q != IDLE || !empty;
        status           = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
        status[ST_PAR]   = PAR_EN;
        rdata_d   = ren ? (hit_st ? status : '0) : rdata_q;
        // a dropped push wins over a same-cycle clear
        ovf_d     = (push && full && !pop) || (ovf_q && !(wen && hit_st && wdata[ST_OVF]));
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        baud_d    = (state_q == IDLE || baud_done) ? '0 : baud_q + BAUD_ONE;
        case (state_q)
            IDLE:  if (!empty) state_d = START;
            START: if (baud_done) state_d = DATA;
            DATA:  if (baud_done) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = AFTER_DATA;
            end
`ifdef UART_PARITY_EN
            PARITY: if (baud_done) state_d = STOP;
`endif
            STOP:  if (baud_done) state_d = empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
        if (pop) shift_d = fifo_dout;
`ifdef UART_PARITY_EN
        par_d = pop ? ^fifo_dout : par_q;
        tx_d  = (state_d == START)  ? 1'b0 :
                (state_d == DATA)   ? shift_d[0] :
                (state_d == PARITY) ? par_q : 1'b1;
`else
        tx_d  = (state_d == START) ? 1'b0 :
                (state_d == DATA)  ? shift_d[0] : 1'b1;
`endif
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign rdata = rdata_q;
    assign tx    = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx against a frame-timeline reference model.
module tb_mmio_uart_tx;
    localparam int DIV = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_0F00;
    localparam logic [31:0] TXA = BASE;
    localparam logic [31:0] STA = BASE + 32'd4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] PB = 32'h0;
`endif
    localparam int FRAME = NBITS * DIV;

    logic CLK = 1'b0, RST = 1'b1, wen = 1'b0, ren = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic tx, busy;
    int errors = 0, checks = 0;

    // reference model: queue of pending bytes plus the timeline of the frame on the line
    logic [7:0] q[$];
    logic [7:0] cur = '0;
    int cyc = 0, t_free = 0, pop_c = -100000;
    bit ovf = 0;
    logic [31:0] exp_rd = '0;

    typedef struct { bit st; logic [31:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;
    vec_t vt[10];

    always #5 CLK = ~CLK;

    mmio_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
        .rdata(rdata), .tx(tx), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // start bit, 8 data bits LSB first, optional even parity, stop bit
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        ovf = 0;
        exp_rd = '0;
        pop_c = -100000;
        t_free = cyc;
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] st;
        logic exp_tx;
        wen = w; ren = r; addr = a; wdata = d;
        st = '0;
        st[0] = q.size() == DEPTH;
        st[1] = q.size() == 0;
        st[2] = q.size() > 0 || cyc < t_free;
        st[3] = ovf;
        st = st | PB;
        if (r) exp_rd = (a[31:2] == STA[31:2]) ? st : 32'h0;
        cyc++;
        if (q.size() > 0 && cyc >= t_free) begin
            cur = q.pop_front();
            pop_c = cyc;
            t_free = cyc + FRAME;
        end
        if (w && a[31:2] == TXA[31:2]) begin
            if (q.size() < DEPTH) q.push_back(d[7:0]);
            else ovf = 1;
        end else if (w && a[31:2] == STA[31:2] && d[3]) ovf = 0;
        @(posedge CLK);
        #1;
        wen = 0; ren = 0;
        exp_tx = (cyc - pop_c < FRAME) ? exp_bit(cur, (cyc - pop_c) / DIV) : 1'b1;
        chk("tx", tx, exp_tx);
        chk("busy", busy, q.size() > 0 || cyc < t_free);
        chk("rdata", rdata, exp_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 * FRAME && (q.size() > 0 || cyc < t_free); i++) idle(1);
        chk("drain", busy, 0);
    endtask

    initial begin
        int n;
        int r;
        vt[0] = '{0, STA, 0, 32'h2 | PB};
        vt[1] = '{0, BASE + 32'd7, 0, 32'h2 | PB};
        vt[2] = '{0, TXA, 0, 32'h0};
        vt[3] = '{0, BASE + 32'd8, 0, 32'h0};
        vt[4] = '{1, BASE + 32'd8, 32'h55, 32'h0};
        vt[5] = '{1, BASE + 32'h1000, 32'hAA, 32'h0};
        vt[6] = '{0, STA, 0, 32'h2 | PB};
        vt[7] = '{1, STA, 32'hFFFF_FFFF, 32'h0};
        vt[8] = '{0, STA, 0, 32'h2 | PB};
        vt[9] = '{0, 32'h0, 0, 32'h0};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        RST = 0;
        model_reset();

        // register map vectors on an idle transmitter
        foreach (vt[i]) begin
            step(vt[i].st, !vt[i].st, vt[i].a, vt[i].d);
            if (!vt[i].st) chk($sformatf("vec%0d", i), rdata, vt[i].exp);
        end
        idle(2);
        chk("rdata_hold", rdata, 32'h0);

        // single frame and its exact length
        step(1, 0, TXA, 32'hA5);
        n = 0;
        while (busy && n < 200) begin idle(1); n++; end
        chk("a5_len", n, FRAME + 1);

        // back-to-back frames: model requires no idle gap
        step(1, 0, TXA, 32'h01);
        step(1, 0, TXA, 32'h02);
        drain();

        // overflow and the push that coincides with a pop
        step(1, 0, TXA, 32'h30);
        idle(1);
        for (int i = 1; i <= 8; i++) step(1, 0, TXA, 32'h30 + i);
        step(0, 1, STA, 0);
        chk("full_status", rdata, 32'h5 | PB);
        step(1, 0, TXA, 32'h39);
        step(0, 1, STA, 0);
        chk("ovf_set", rdata[3], 1);
        step(1, 0, STA, 32'h8);
        step(0, 1, STA, 0);
        chk("ovf_clr", rdata[3], 0);
        for (int i = 0; i < 2 * FRAME && cyc + 1 != t_free; i++) idle(1);
        step(1, 0, TXA, 32'h3A);
        step(0, 1, STA, 0);
        chk("push_on_pop", rdata, 32'h5 | PB);
        drain();

        // reset in the middle of a frame with three bytes queued
        for (int i = 0; i < 4; i++) step(1, 0, TXA, 32'hC0 + i);
        for (int i = 0; i < 4 * FRAME && cyc != pop_c + 5 * DIV + 1; i++) idle(1);
        RST = 1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        model_reset();
        idle(2);
        RST = 0;
        model_reset();
        step(0, 1, STA, 0);
        chk("post_rst_status", rdata, 32'h2 | PB);
        idle(3 * FRAME);

`ifdef UART_PARITY_EN
        step(1, 0, TXA, 32'h07);
        n = 0;
        while (busy && n < 200) begin idle(1); n++; end
        chk("par_len", n, 45);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) step(1, 0, TXA, $urandom);
            else if (r < 20) step(0, 1, STA, 0);
            else if (r < 23) step(1, 0, STA, $urandom);
            else if (r < 26) step(0, 1, BASE + ($urandom_range(0, 3) << 2), 0);
            else if (r < 28) step($urandom_range(0, 1), 0, $urandom, $urandom);
            else idle(1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory side of the core, consuming the same store stream (address, write data, write strobe) that the data memory sees. Stores to the TX data register push bytes into an internal FIFO. A baud-rate FSM serialises each byte onto `tx`. A status register reports FIFO and sticky-overflow state to core loads.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per UART bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0F00: word-aligned base of the 2-register window.

Ports:
- `CLK`  in  1  system clock; all logic rising-edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `wen`  in  1  store strobe from the core.
- `ren`  in  1  load strobe from the core.
- `addr`  in  32  byte address; `addr[1:0]` ignored.
- `wdata`  in  32  store data.
- `rdata`  out  32  registered load data.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is shifting or the FIFO is non-empty.

## Operation
- Register map:
  - `BASE_ADDR+0` TXDATA, write-only. Pushes `wdata[7:0]`.
  - `BASE_ADDR+4` STATUS. Read bits: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky). Writing with `wdata[3]=1` clears overflow; other bits are ignored.
- Address match compares `addr[31:2]` only. Stores to other addresses are ignored; loads from other addresses return 0.
- Push on full FIFO:
  - Without a same-cycle pop, the byte is dropped and overflow is set.
  - With a same-cycle pop, the push is accepted.
- Overflow set and clear in the same cycle: set wins.
- FSM states IDLE, START, DATA, PARITY (macro only), STOP:
  - IDLE→START when FIFO is non-empty. The byte is popped into the shift register in the same cycle.
  - START holds `tx=0` for `CLK_DIV` cycles → DATA.
  - DATA shifts 8 bits, LSB first, `CLK_DIV` cycles each → PARITY or STOP.
  - PARITY holds one bit for `CLK_DIV` cycles → STOP.
  - STOP holds `tx=1` for `CLK_DIV` cycles. Then → START directly if the FIFO is non-empty (pop in that cycle, no idle gap); else → IDLE.
- Baud counter counts 0..`CLK_DIV`-1, reloads at each bit boundary, width `$clog2(CLK_DIV)`. Bit index counter is 3 bits and wraps after bit 7.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits, wrap naturally. Full/empty come from the MSB compare.

## Timing
- Reset values: `tx=1`, `rdata=0`, `busy=0`, FSM=IDLE, FIFO empty, overflow=0, all counters 0.
- Reset asserted mid-frame: `tx` returns high asynchronously, the FIFO is flushed, and the in-flight byte is lost.
- Store captured at edge N:
  - FIFO count and STATUS reflect the push after edge N.
  - With an idle FSM, the pop happens at edge N+1 and `tx` falls after edge N+1.
- Load: `rdata` is valid one cycle after the `ren` cycle and holds until the next `ren`.
- Frame length is exactly 10·`CLK_DIV` cycles, or 11·`CLK_DIV` with parity.
- `busy` asserts the cycle after the first push and deasserts after the final stop bit completes with the FIFO empty.

## Configuration
- `UART_PARITY_EN`:
  - Defined: the PARITY state is compiled in and emits even parity (XOR of the 8 data bits) between DATA and STOP. STATUS bit4 reads 1.
  - Undefined: the PARITY state and its logic are absent, the frame is 8N1, and STATUS bit4 reads 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Register offsets `TXDATA_OFS=0` and `STATUS_OFS=4`.
  - STATUS bit-position constants.
- Sub-module `sync_fifo`: parameterised width and depth, same `CLK`/`RST`, push/pop/full/empty/dout. The FIFO is instantiated once for 8-bit data.

## Test plan
- Reset → `tx=1`, STATUS read returns 32'h0000_0002, `busy=0`.
- `CLK_DIV=4`, store 8'hA5 to TXDATA → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Total 40 cycles, then `busy=0`.
- `CLK_DIV=4`, store 8'h01 then 8'h02 on consecutive cycles → two frames with no idle cycle between stop bit and start bit.
- Store 9 bytes into the 8-deep FIFO while the first frame is still shifting → 9th accepted only if it coincides with the pop; otherwise STATUS bit3=1. Store `wdata[3]=1` to STATUS → bit3 returns 0.
- Assert `RST` at bit 4 of a frame with 3 bytes queued → `tx=1` immediately. After release, STATUS reads empty and no further frames are sent.
- `UART_PARITY_EN` defined, `CLK_DIV=4`, byte 8'h07 → parity bit 1, frame length 44 cycles.
